mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the single data-memory port between the instruction cache and the data cache for the pipelined RISC-V CPU. Each cache controller raises a block read (I-cache) or block read/write (D-cache) on a miss or write-back. The arbiter picks one requester and drives the memory handshake for it. It returns fill data and a per-requester busywait, so the caches never drive the memory bus directly.

## Interface
- ADDR_WIDTH, 32, byte address width on requester and memory sides
- DATA_WIDTH, 128, block width (one cache line per transfer)
- clock  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; forces all state and outputs to reset values immediately
- i_read  in  1  I-cache block read request, held until i_busywait falls
- i_address  in  ADDR_WIDTH  I-cache block address, stable while i_read high
- i_readdata  out  DATA_WIDTH  fill data for I-cache, registered
- i_busywait  out  1  high while I-cache request pending and not yet completed
- d_read  in  1  D-cache block read request
- d_write  in  1  D-cache block write-back request
- d_address  in  ADDR_WIDTH  D-cache block address
- d_writedata  in  DATA_WIDTH  write-back block
- d_readdata  out  DATA_WIDTH  fill data for D-cache, registered
- d_busywait  out  1  high while D-cache request pending and not yet completed
- mem_read  out  1  memory read strobe, registered
- mem_write  out  1  memory write strobe, registered
- mem_address  out  ADDR_WIDTH  latched address of granted request
- mem_writedata  out  DATA_WIDTH  latched write data of granted request
- mem_readdata  in  DATA_WIDTH  memory read block, valid when mem_busywait low in WAIT
- mem_busywait  in  1  memory busy; low signals transfer complete

## Operation
- States: IDLE, ISSUE, WAIT, DONE. Registers: state, grant (I/D), last_grant, op latch, address/data latches, done pulse.
- i_req = i_read; d_req = d_read | d_write. If d_read and d_write are both high, treat the request as a write.
- IDLE: if no request, stay. If exactly one requester is active, grant it. If both are active, grant the one not equal to last_grant (round-robin).
- On grant, latch address, writedata (D write only) and op; set mem_read or mem_write; go to ISSUE; update last_grant.
- ISSUE: hold strobes for one cycle and ignore mem_busywait, which covers memory raise latency. Go to WAIT.
- WAIT: hold strobes. On an edge where mem_busywait == 0:
  - clear strobes;
  - for a read, capture mem_readdata into i_readdata or d_readdata per grant;
  - set done for the granted requester;
  - go to DONE.
- DONE: one cycle, then IDLE. Clear done on exit.
- i_busywait = i_read & ~i_done, and d_busywait = d_req & ~d_done. These are combinational from the request and a registered done. A non-granted requester stays busy.
- If a requester drops its request mid-transfer, the transfer still completes and the data is captured; the done pulse is harmless.
- i_readdata and d_readdata hold their last captured value until the next read for that requester. A write never alters d_readdata.
- mem_address and mem_writedata hold their last latched values when idle.

## Timing
- Reset values: state IDLE, last_grant = I (so the first tie goes to D), mem_read = mem_write = 0, mem_address = 0, mem_writedata = 0, i_readdata = d_readdata = 0, done = 0.
- Consequence at reset: i_busywait and d_busywait follow their request inputs.
- Reset asserted mid-transfer clears the strobes immediately. Pending requests are re-arbitrated from IDLE after reset releases.
- Cycle numbering: request sampled at edge N in IDLE; memory completes when mem_busywait is first sampled low at edge M.
  - Strobe high after edge N. ISSUE spans N..N+1. WAIT is entered at N+1.
  - M ≥ N+2. At M: strobe low, data valid, busywait low.
  - Requester drops its request at edge M+1, when DONE exits to IDLE.
- The minimum request-to-busywait-low time is 2 cycles. The next grant is no earlier than edge M+2.
- There is no back-to-back grant without passing through IDLE. The second requester waits at least M+2-N cycles.

## Test plan
- Single I read, i_address=0x0000_0040, memory busy 5 cycles, returns 0xDEADBEEF_00000000_11111111_CAFEF00D -> mem_read high 6 cycles, i_readdata equals the block, i_busywait low exactly after the completion edge, d_* unchanged.
- Simultaneous d_write(0x80, data A) and i_read(0x100) right after reset -> D granted first (mem_write, address 0x80, writedata A), then I granted (mem_read, address 0x100). d_readdata stays 0.
- Both requesters continuously re-request 4 times -> grants alternate D, I, D, I; neither busywait stays high beyond 2 transfers.
- d_read and d_write both high, address 0x200 -> mem_write asserted, mem_read never asserted.
- reset driven low during WAIT of a D read -> mem_read and busywaits-done cleared within the same cycle, d_readdata = 0. After release, the still-held d_read is re-issued from IDLE.
- mem_busywait already low at the ISSUE edge -> completion not before edge N+2, and data is captured at the first low sample in WAIT.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one block-wide memory port between the I-cache and the D-cache.
//   clock, reset            - system clock, asynchronous active-low reset
//   i_read/i_address        - I-cache block read request
//   i_readdata/i_busywait   - I-cache fill data (registered) and busy flag
//   d_read/d_write/d_address/d_writedata - D-cache block read / write-back request
//   d_readdata/d_busywait   - D-cache fill data (registered) and busy flag
//   mem_read/mem_write/mem_address/mem_writedata - registered memory request
//   mem_readdata/mem_busywait - memory response
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 128
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0] i_readdata,
    output logic                  i_busywait,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [DATA_WIDTH-1:0] d_writedata,
    output logic [DATA_WIDTH-1:0] d_readdata,
    output logic                  d_busywait,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_writedata,
    input  logic [DATA_WIDTH-1:0] mem_readdata,
    input  logic                  mem_busywait
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state_q, state_n;
    logic                  grant_d_q, grant_d_n;    // 1: D-cache owns the transfer
    logic                  last_d_q, last_d_n;      // 1: last grant went to D-cache
    logic                  op_wr_q, op_wr_n;
    logic                  i_done_q, i_done_n;
    logic                  d_done_q, d_done_n;
    logic                  mem_read_n, mem_write_n;
    logic [ADDR_WIDTH-1:0] mem_address_n;
    logic [DATA_WIDTH-1:0] mem_writedata_n;
    logic [DATA_WIDTH-1:0] i_readdata_n, d_readdata_n;
    logic                  d_req;
    logic                  pick_d;

    assign d_req      = d_read | d_write;
    assign i_busywait = i_read & ~i_done_q;
    assign d_busywait = d_req & ~d_done_q;

    // State and output registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            grant_d_q     <= 1'b0;
            last_d_q      <= 1'b0;
            op_wr_q       <= 1'b0;
            i_done_q      <= 1'b0;
            d_done_q      <= 1'b0;
            mem_read      <= 1'b0;
            mem_write     <= 1'b0;
            mem_address   <= '0;
            mem_writedata <= '0;
            i_readdata    <= '0;
            d_readdata    <= '0;
        end else begin
            state_q       <= state_n;
            grant_d_q     <= grant_d_n;
            last_d_q      <= last_d_n;
            op_wr_q       <= op_wr_n;
            i_done_q      <= i_done_n;
            d_done_q      <= d_done_n;
            mem_read      <= mem_read_n;
            mem_write     <= mem_write_n;
            mem_address   <= mem_address_n;
            mem_writedata <= mem_writedata_n;
            i_readdata    <= i_readdata_n;
            d_readdata    <= d_readdata_n;
        end
    end

    // Arbitration, memory handshake and next-state logic
    always_comb begin
        state_n         = state_q;
        grant_d_n       = grant_d_q;
        last_d_n        = last_d_q;
        op_wr_n         = op_wr_q;
        i_done_n        = i_done_q;
        d_done_n        = d_done_q;
        mem_read_n      = mem_read;
        mem_write_n     = mem_write;
        mem_address_n   = mem_address;
        mem_writedata_n = mem_writedata;
        i_readdata_n    = i_readdata;
        d_readdata_n    = d_readdata;
        pick_d          = 1'b0;

        case (state_q)
            IDLE: begin
                if (i_read || d_req) begin
                    // Sole requester wins; on a tie the one not granted last time wins
                    pick_d        = d_req && (!i_read || !last_d_q);
                    grant_d_n     = pick_d;
                    last_d_n      = pick_d;
                    op_wr_n       = pick_d && d_write;
                    mem_address_n = pick_d ? d_address : i_address;
                    if (pick_d && d_write) begin
                        mem_writedata_n = d_writedata;
                    end
                    mem_read_n  = !(pick_d && d_write);
                    mem_write_n = pick_d && d_write;
                    state_n     = ISSUE;
                end
            end
            // Memory may not have raised busywait yet, so it is ignored here
            ISSUE: state_n = WAIT;
            WAIT: begin
                if (!mem_busywait) begin
                    mem_read_n  = 1'b0;
                    mem_write_n = 1'b0;
                    if (!op_wr_q) begin
                        if (grant_d_q) begin
                            d_readdata_n = mem_readdata;
                        end else begin
                            i_readdata_n = mem_readdata;
                        end
                    end
                    if (grant_d_q) begin
                        d_done_n = 1'b1;
                    end else begin
                        i_done_n = 1'b1;
                    end
                    state_n = DONE;
                end
            end
            DONE: begin
                i_done_n = 1'b0;
                d_done_n = 1'b0;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a latency-programmable memory model.
module tb_mem_arbiter;

    logic         clock;
    logic         reset;
    logic         i_read;
    logic [31:0]  i_address;
    logic [127:0] i_readdata;
    logic         i_busywait;
    logic         d_read;
    logic         d_write;
    logic [31:0]  d_address;
    logic [127:0] d_writedata;
    logic [127:0] d_readdata;
    logic         d_busywait;
    logic         mem_read;
    logic         mem_write;
    logic [31:0]  mem_address;
    logic [127:0] mem_writedata;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] data;   // write data for writes, fill data for reads
        logic         is_d;
    } exp_t;

    exp_t q[$];
    int   total;
    int   bad;
    int   lat;
    int   cnt;

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(128)) dut (
        .clock(clock), .reset(reset),
        .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
        .d_readdata(d_readdata), .d_busywait(d_busywait),
        .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
        .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory model: busy for `lat` edges after the strobe is first seen at an edge
    always @(posedge clock or negedge reset) begin
        if (!reset) cnt <= 0;
        else if (mem_read || mem_write) cnt <= cnt + 1;
        else cnt <= 0;
    end
    assign mem_busywait = (mem_read || mem_write) && (cnt < lat);

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Waits for one complete transfer; returns right after the completion edge
    task automatic observe(output logic wr, output logic [31:0] addr, output logic [127:0] wd,
                           output int hi, output bit rd_seen, output bit ib_all,
                           output bit db_all, output bit tmo);
        tmo = 1'b1; hi = 0; rd_seen = 1'b0; ib_all = 1'b1; db_all = 1'b1;
        wr = 1'b0; addr = '0; wd = '0;
        for (int t = 0; t < 300; t++) begin
            tick();
            if (mem_read || mem_write) begin
                if (hi == 0) begin
                    wr = mem_write; addr = mem_address; wd = mem_writedata;
                end
                hi++;
                rd_seen = rd_seen | mem_read;
                ib_all  = ib_all & i_busywait;
                db_all  = db_all & d_busywait;
            end else if (hi > 0) begin
                tmo = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; i_read = 1'b1; d_read = 1'b0; d_write = 1'b0;
        i_address = 32'h0; d_address = 32'h0; d_writedata = '0; mem_readdata = '0; lat = 0;
        tick(); tick();
        total++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin bad++; $display("FAIL rst_strobe got=%b%b exp=00", mem_read, mem_write); end
        total++; if (mem_address !== 32'h0) begin bad++; $display("FAIL rst_addr got=%h exp=0", mem_address); end
        total++; if (mem_writedata !== 128'h0) begin bad++; $display("FAIL rst_wdata got=%h exp=0", mem_writedata); end
        total++; if (i_readdata !== 128'h0 || d_readdata !== 128'h0) begin bad++; $display("FAIL rst_rdata got=%h/%h exp=0/0", i_readdata, d_readdata); end
        total++; if (i_busywait !== 1'b1 || d_busywait !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b%b exp=10", i_busywait, d_busywait); end
        i_read = 1'b0;
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_single_i_read();
        logic wr; logic [31:0] a; logic [127:0] wd; int hi; bit rs, ib, db, tmo; exp_t e;
        lat = 5;
        mem_readdata = 128'hDEADBEEF_00000000_11111111_CAFEF00D;
        i_address = 32'h0000_0040; i_read = 1'b1;
        q.push_back('{wr: 1'b0, addr: 32'h40, data: mem_readdata, is_d: 1'b0});
        observe(wr, a, wd, hi, rs, ib, db, tmo);
        e = q.pop_front();
        total++; if (tmo) begin bad++; $display("FAIL t1_timeout got=none exp=transfer"); end
        total++; if (wr !== e.wr || a !== e.addr) begin bad++; $display("FAIL t1_req got=%b/%h exp=%b/%h", wr, a, e.wr, e.addr); end
        total++; if (hi != 6) begin bad++; $display("FAIL t1_strobe_len got=%0d exp=6", hi); end
        total++; if (i_readdata !== e.data) begin bad++; $display("FAIL t1_rdata got=%h exp=%h", i_readdata, e.data); end
        total++; if (!ib || i_busywait !== 1'b0) begin bad++; $display("FAIL t1_busy got=hold%b/now%b exp=1/0", ib, i_busywait); end
        total++; if (d_readdata !== 128'h0 || d_busywait !== 1'b0 || mem_writedata !== 128'h0) begin bad++; $display("FAIL t1_d_side got=%h/%b/%h exp=0/0/0", d_readdata, d_busywait, mem_writedata); end
        tick();
        total++; if (i_busywait !== 1'b1) begin bad++; $display("FAIL t1_done_pulse got=%b exp=1", i_busywait); end
        i_read = 1'b0;
        tick();
        total++; if (mem_read !== 1'b0 || i_readdata !== e.data) begin bad++; $display("FAIL t1_hold got=%b/%h exp=0/%h", mem_read, i_readdata, e.data); end
    endtask

    task automatic test_tie_after_reset();
        logic wr; logic [31:0] a; logic [127:0] wd; int hi; bit rs, ib, db, tmo; exp_t e;
        reset = 1'b0;
        lat = 3;
        d_write = 1'b1; d_address = 32'h80; d_writedata = 128'hAAAA_5555_0123_4567_89AB_CDEF_F0F0_0F0F;
        i_read = 1'b1; i_address = 32'h100;
        mem_readdata = 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321;
        q.push_back('{wr: 1'b1, addr: 32'h80, data: d_writedata, is_d: 1'b1});
        q.push_back('{wr: 1'b0, addr: 32'h100, data: mem_readdata, is_d: 1'b0});
        tick(); tick();
        reset = 1'b1;
        observe(wr, a, wd, hi, rs, ib, db, tmo);
        e = q.pop_front();
        total++; if (tmo || wr !== e.wr || a !== e.addr || wd !== e.data) begin bad++; $display("FAIL t2_first got=%b/%h/%h tmo=%b exp=%b/%h/%h", wr, a, wd, tmo, e.wr, e.addr, e.data); end
        total++; if (d_busywait !== 1'b0 || i_busywait !== 1'b1) begin bad++; $display("FAIL t2_busy1 got=d%b i%b exp=d0 i1", d_busywait, i_busywait); end
        tick();
        d_write = 1'b0;
        observe(wr, a, wd, hi, rs, ib, db, tmo);
        e = q.pop_front();
        total++; if (tmo || wr !== e.wr || a !== e.addr) begin bad++; $display("FAIL t2_second got=%b/%h tmo=%b exp=%b/%h", wr, a, tmo, e.wr, e.addr); end
        total++; if (i_readdata !== e.data || d_readdata !== 128'h0) begin bad++; $display("FAIL t2_rdata got=%h/%h exp=%h/0", i_readdata, d_readdata, e.data); end
        tick();
        i_read = 1'b0;
    endtask

    task automatic test_round_robin();
        logic wr; logic [31:0] a; logic [127:0] wd; int hi; bit rs, ib, db, tmo; exp_t e;
        lat = 2;
        d_read = 1'b1; d_address = 32'h300; i_read = 1'b1; i_address = 32'h400;
        for (int k = 0; k < 8; k++) begin
            mem_readdata = {$urandom, $urandom, $urandom, $urandom};
            q.push_back('{wr: 1'b0, addr: (k % 2 == 0) ? 32'h300 : 32'h400, data: mem_readdata, is_d: (k % 2 == 0)});
            observe(wr, a, wd, hi, rs, ib, db, tmo);
            e = q.pop_front();
            total++; if (tmo || wr !== 1'b0 || a !== e.addr) begin bad++; $display("FAIL t3_grant%0d got=%b/%h tmo=%b exp=0/%h", k, wr, a, tmo, e.addr); end
            if (e.is_d) begin
                total++; if (d_readdata !== e.data || d_busywait !== 1'b0 || i_busywait !== 1'b1) begin bad++; $display("FAIL t3_d%0d got=%h/%b/%b exp=%h/0/1", k, d_readdata, d_busywait, i_busywait, e.data); end
            end else begin
                total++; if (i_readdata !== e.data || i_busywait !== 1'b0 || d_busywait !== 1'b1) begin bad++; $display("FAIL t3_i%0d got=%h/%b/%b exp=%h/0/1", k, i_readdata, i_busywait, d_busywait, e.data); end
            end
        end
        tick();
        d_read = 1'b0; i_read = 1'b0;
    endtask

    task automatic test_read_write_both();
        logic wr; logic [31:0] a; logic [127:0] wd; int hi; bit rs, ib, db, tmo; exp_t e;
        logic [127:0] d_prev;
        d_prev = d_readdata;
        lat = 1;
        mem_readdata = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h200; d_writedata = 128'hB0B0_1111_2222_3333_4444_5555_6666_7777;
        q.push_back('{wr: 1'b1, addr: 32'h200, data: d_writedata, is_d: 1'b1});
        observe(wr, a, wd, hi, rs, ib, db, tmo);
        e = q.pop_front();
        total++; if (tmo || wr !== 1'b1 || rs !== 1'b0) begin bad++; $display("FAIL t4_op got=wr%b rd%b tmo=%b exp=wr1 rd0", wr, rs, tmo); end
        total++; if (a !== e.addr || wd !== e.data) begin bad++; $display("FAIL t4_req got=%h/%h exp=%h/%h", a, wd, e.addr, e.data); end
        total++; if (d_readdata !== d_prev) begin bad++; $display("FAIL t4_rdata_kept got=%h exp=%h", d_readdata, d_prev); end
        tick();
        d_read = 1'b0; d_write = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        logic wr; logic [31:0] a; logic [127:0] wd; int hi; bit rs, ib, db, tmo; exp_t e;
        bit seen;
        lat = 20; seen = 1'b0;
        d_read = 1'b1; d_address = 32'h500;
        for (int t = 0; t < 20 && !seen; t++) begin
            tick();
            seen = mem_read;
        end
        total++; if (!seen) begin bad++; $display("FAIL t5_issue got=no_strobe exp=strobe"); end
        tick(); tick(); tick();
        #3 reset = 1'b0;
        #1;
        total++; if (mem_read !== 1'b0 || d_readdata !== 128'h0 || mem_address !== 32'h0) begin bad++; $display("FAIL t5_async got=%b/%h/%h exp=0/0/0", mem_read, d_readdata, mem_address); end
        total++; if (d_busywait !== 1'b1) begin bad++; $display("FAIL t5_busy got=%b exp=1", d_busywait); end
        tick(); tick();
        lat = 3;
        mem_readdata = 128'h5151_5151_A5A5_A5A5_0000_FFFF_1357_9BDF;
        reset = 1'b1;
        q.push_back('{wr: 1'b0, addr: 32'h500, data: mem_readdata, is_d: 1'b1});
        observe(wr, a, wd, hi, rs, ib, db, tmo);
        e = q.pop_front();
        total++; if (tmo || wr !== 1'b0 || a !== e.addr) begin bad++; $display("FAIL t5_reissue got=%b/%h tmo=%b exp=0/%h", wr, a, tmo, e.addr); end
        total++; if (d_readdata !== e.data) begin bad++; $display("FAIL t5_rdata got=%h exp=%h", d_readdata, e.data); end
        tick();
        d_read = 1'b0;
        tick();
    endtask

    task automatic test_early_ready();
        logic wr; logic [31:0] a; logic [127:0] wd; int hi; bit rs, ib, db, tmo; exp_t e;
        lat = 0;
        mem_readdata = 128'hE0E0_E1E1_E2E2_E3E3_E4E4_E5E5_E6E6_E7E7;
        i_read = 1'b1; i_address = 32'h600;
        q.push_back('{wr: 1'b0, addr: 32'h600, data: mem_readdata, is_d: 1'b0});
        observe(wr, a, wd, hi, rs, ib, db, tmo);
        e = q.pop_front();
        total++; if (tmo || hi != 2) begin bad++; $display("FAIL t6_len got=%0d tmo=%b exp=2", hi, tmo); end
        total++; if (!ib || i_busywait !== 1'b0) begin bad++; $display("FAIL t6_busy got=hold%b/now%b exp=1/0", ib, i_busywait); end
        total++; if (a !== e.addr || i_readdata !== e.data) begin bad++; $display("FAIL t6_data got=%h/%h exp=%h/%h", a, i_readdata, e.addr, e.data); end
        tick();
        i_read = 1'b0;
        tick();
    endtask

    initial begin
        total = 0; bad = 0;
        test_reset();
        test_single_i_read();
        test_tie_after_reset();
        test_round_robin();
        test_read_write_both();
        test_reset_mid();
        test_early_ready();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
